// File: rtl/conv_result_serializer.sv
// ----------------------------------------------------------------------------
// conv_result_serializer
//
// Purpose:
//   Downstream stage of the 2x2 systolic convolution array.
//   - On each rising edge of done_2_2, the four parallel results are captured
//     into a holding bank.
//   - The captured words are streamed one per beat over a valid/ready
//     interface in raster order: result11, result12, result21, result22.
//   - A completion edge that arrives while a frame is still draining is
//     dropped, and the sticky overrun flag is raised.
//
// Optional feature (macro CONV_RESULT_MAXPOOL_EN):
//   When defined, a fifth word is stored on capture and sent last. It holds
//   the unsigned maximum of the four results. The frame is then 5 words long.
//   When undefined, no comparator is built and the frame is 4 words long.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   done_2_2  in   completion flag from the array (level; edge-detected here)
//   result11  in   DATA_W  array result row 1 col 1
//   result12  in   DATA_W  array result row 1 col 2
//   result21  in   DATA_W  array result row 2 col 1
//   result22  in   DATA_W  array result row 2 col 2
//   out_data  out  DATA_W  current stream word
//   out_valid out  out_data is valid
//   out_ready in   consumer accepts the word when high together with out_valid
//   out_last  out  final word of a frame
//   busy      out  a frame is captured and not yet fully drained
//   overrun   out  sticky: a completion arrived while busy
// ----------------------------------------------------------------------------
module conv_result_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_2_2,
    input  logic [DATA_W-1:0] result11,
    input  logic [DATA_W-1:0] result12,
    input  logic [DATA_W-1:0] result21,
    input  logic [DATA_W-1:0] result22,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

`ifdef CONV_RESULT_MAXPOOL_EN
    localparam int         NWORDS   = 5;
    localparam logic [2:0] LAST_IDX = 3'd4;

    // Unsigned maximum of two words. On a tie, either value is correct.
    function automatic logic [DATA_W-1:0] umax2(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction
`else
    localparam int         NWORDS   = 4;
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        idx_r;
    logic [2:0]        idx_nxt_s;
    logic              done_prev_r;
    logic              overrun_r;
    logic [DATA_W-1:0] bank_r [NWORDS];

    logic              start_s;
    logic              xfer_s;
    logic              last_s;
    logic              capture_s;
    logic              overrun_set_s;
    logic [DATA_W-1:0] word_s;

    assign start_s = done_2_2 & ~done_prev_r;
    assign xfer_s  = (state_r == SEND) & out_ready;
    assign last_s  = (idx_r == LAST_IDX);

    // Next-state logic: decides capture, index advance and overrun detection.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        capture_s     = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    capture_s   = 1'b1;
                    idx_nxt_s   = 3'd0;
                    state_nxt_s = SEND;
                end else begin
                    idx_nxt_s   = 3'd0;
                end
            end
            SEND: begin
                if (xfer_s && last_s) begin
                    // The bank is free on this edge. A new edge can refill it
                    // without a bubble.
                    idx_nxt_s = 3'd0;
                    if (start_s) begin
                        capture_s   = 1'b1;
                        state_nxt_s = SEND;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    if (xfer_s) begin
                        idx_nxt_s = idx_r + 3'd1;
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                    if (start_s) begin
                        overrun_set_s = 1'b1;
                    end else begin
                        overrun_set_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    // Control state: FSM state, word index, edge-detect history and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            idx_r       <= 3'd0;
            done_prev_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            done_prev_r <= done_2_2;
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Holding bank: loaded only on a capture edge, so the frame in flight stays frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                bank_r[i] <= {DATA_W{1'b0}};
            end
        end else if (capture_s) begin
            bank_r[0] <= result11;
            bank_r[1] <= result12;
            bank_r[2] <= result21;
            bank_r[3] <= result22;
`ifdef CONV_RESULT_MAXPOOL_EN
            bank_r[4] <= umax2(umax2(result11, result12), umax2(result21, result22));
`endif
        end
    end

    // Output word mux: selects the bank word by index, and forces zero while idle.
    always_comb begin
        word_s = {DATA_W{1'b0}};
        if (state_r == SEND) begin
            case (idx_r)
                3'd0:    word_s = bank_r[0];
                3'd1:    word_s = bank_r[1];
                3'd2:    word_s = bank_r[2];
                3'd3:    word_s = bank_r[3];
`ifdef CONV_RESULT_MAXPOOL_EN
                3'd4:    word_s = bank_r[4];
`endif
                default: word_s = {DATA_W{1'b0}};
            endcase
        end else begin
            word_s = {DATA_W{1'b0}};
        end
    end

    assign out_data  = word_s;
    assign out_valid = (state_r == SEND);
    assign busy      = (state_r == SEND);
    assign out_last  = (state_r == SEND) & last_s;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_conv_result_serializer.sv
// ----------------------------------------------------------------------------
// tb_conv_result_serializer
//
// Directed testbench for conv_result_serializer. It covers:
//   - the reset state
//   - a basic frame
//   - backpressure
//   - done_2_2 held as a level
//   - overrun
//   - back-to-back frames
//   - asynchronous reset in the middle of a frame
// Inputs are changed 1 ns after each rising clock edge. Outputs are checked
// at the same point.
// ----------------------------------------------------------------------------
module tb_conv_result_serializer;

    localparam int DW = 8;

`ifdef CONV_RESULT_MAXPOOL_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic          clk;
    logic          rst;
    logic          done_2_2;
    logic [DW-1:0] result11;
    logic [DW-1:0] result12;
    logic [DW-1:0] result21;
    logic [DW-1:0] result22;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          overrun;

    int checks;
    int errors;

    // Expected frames. The fifth entry is the maximum of the four results.
    logic [DW-1:0] fa [5];
    logic [DW-1:0] fb [5];

    conv_result_serializer #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_2_2  (done_2_2),
        .result11  (result11),
        .result12  (result12),
        .result21  (result21),
        .result22  (result22),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        result11 = 8'd12; result12 = 8'd10; result21 = 8'd9; result22 = 8'd10;
    endtask

    task automatic load_b();
        result11 = 8'd1; result12 = 8'd2; result21 = 8'd3; result22 = 8'd4;
    endtask

    task automatic expect_beat(input string tag, input logic [DW-1:0] d, input logic lst);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
        check({tag, ".last"},  {31'd0, out_last},  {31'd0, lst});
        check({tag, ".busy"},  {31'd0, busy},      32'd1);
    endtask

    task automatic expect_idle(input string tag, input logic ovr);
        check({tag, ".valid"},   {31'd0, out_valid}, 32'd0);
        check({tag, ".busy"},    {31'd0, busy},      32'd0);
        check({tag, ".last"},    {31'd0, out_last},  32'd0);
        check({tag, ".data"},    {24'd0, out_data},  32'd0);
        check({tag, ".overrun"}, {31'd0, overrun},   {31'd0, ovr});
    endtask

    // Starts a frame: raises done_2_2 for one edge with the given results already loaded.
    task automatic pulse_done();
        done_2_2 = 1'b1;
        step();
        done_2_2 = 1'b0;
    endtask

    // Applies reset between edges and releases it on a falling edge.
    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // Directed stimulus sequence.
    initial begin
        checks = 0;
        errors = 0;
        fa[0] = 8'd12; fa[1] = 8'd10; fa[2] = 8'd9; fa[3] = 8'd10; fa[4] = 8'd12;
        fb[0] = 8'd1;  fb[1] = 8'd2;  fb[2] = 8'd3; fb[3] = 8'd4;  fb[4] = 8'd4;
        rst = 1'b0; done_2_2 = 1'b0; out_ready = 1'b0;
        result11 = 8'd0; result12 = 8'd0; result21 = 8'd0; result22 = 8'd0;

        // Reset state.
        #1;
        expect_idle("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        expect_idle("post_reset", 1'b0);

        // Basic frame.
        load_a();
        out_ready = 1'b1;
        pulse_done();
        for (int i = 0; i < FL; i++) begin
            expect_beat($sformatf("basic[%0d]", i), fa[i], (i == FL - 1));
            step();
        end
        expect_idle("basic_end", 1'b0);

        // Backpressure at index 1.
        pulse_done();
        expect_beat("bp[0]", fa[0], 1'b0);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_beat($sformatf("bp_hold%0d", k), fa[1], 1'b0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < FL; i++) begin
            expect_beat($sformatf("bp[%0d]", i), fa[i], (i == FL - 1));
            step();
        end
        expect_idle("bp_end", 1'b0);

        // done_2_2 held high for ten edges produces a single frame.
        done_2_2 = 1'b1;
        step();
        for (int i = 0; i < FL; i++) begin
            expect_beat($sformatf("level[%0d]", i), fa[i], (i == FL - 1));
            step();
        end
        for (int k = 0; k < 9 - FL; k++) begin
            expect_idle($sformatf("level_hold%0d", k), 1'b0);
            step();
        end
        done_2_2 = 1'b0;
        expect_idle("level_end", 1'b0);
        step();

        // Overrun: a second edge at index 1 is dropped.
        pulse_done();
        expect_beat("ovr[0]", fa[0], 1'b0);
        step();
        load_b();
        expect_beat("ovr[1]", fa[1], 1'b0);
        pulse_done();
        result11 = 8'd99; result12 = 8'd98; result21 = 8'd97; result22 = 8'd96;
        check("ovr_set", {31'd0, overrun}, 32'd1);
        for (int i = 2; i < FL; i++) begin
            expect_beat($sformatf("ovr[%0d]", i), fa[i], (i == FL - 1));
            step();
        end
        for (int k = 0; k < 3; k++) begin
            expect_idle($sformatf("ovr_sticky%0d", k), 1'b1);
            step();
        end

        // Back-to-back: a new edge arrives on the cycle of the last-beat transfer.
        apply_reset();
        expect_idle("b2b_reset", 1'b0);
        load_a();
        pulse_done();
        for (int i = 0; i < FL - 1; i++) begin
            expect_beat($sformatf("b2b_a[%0d]", i), fa[i], 1'b0);
            step();
        end
        expect_beat("b2b_a_last", fa[FL-1], 1'b1);
        load_b();
        pulse_done();
        for (int i = 0; i < FL; i++) begin
            expect_beat($sformatf("b2b_b[%0d]", i), fb[i], (i == FL - 1));
            check($sformatf("b2b_ovr%0d", i), {31'd0, overrun}, 32'd0);
            step();
        end
        expect_idle("b2b_end", 1'b0);

        // Asynchronous reset at index 2, with overrun already set.
        load_a();
        pulse_done();
        step();
        pulse_done();
        check("ar_ovr_pre", {31'd0, overrun}, 32'd1);
        expect_beat("ar_pre", fa[2], 1'b0);
        #2;
        rst = 1'b0;
        #1;
        expect_idle("ar_immediate", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            expect_idle($sformatf("ar_quiet%0d", k), 1'b0);
            step();
        end
        load_b();
        pulse_done();
        expect_beat("ar_restart", fb[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_result_serializer.md
Name: conv_result_serializer

Overview:
- Downstream stage of the 2x2 systolic convolution array.
- On each completed convolution (rising edge of done_2_2), captures the four parallel results result11..result22 into a holding bank.
- Streams the captured results one word per beat over a valid/ready interface to the next consumer (pooling, writeback or UART bridge).
- Decouples the array from consumer backpressure and flags results lost while a frame is still draining.

Parameters:
DATA_W, 8, width of each result word and of out_data

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
done_2_2  input  1  completion flag from the systolic array; may stay high for several cycles
result11  input  DATA_W  array result, row 1 col 1
result12  input  DATA_W  array result, row 1 col 2
result21  input  DATA_W  array result, row 2 col 1
result22  input  DATA_W  array result, row 2 col 2
out_data  output  DATA_W  current stream word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts word when high with out_valid
out_last  output  1  marks final word of a frame
busy  output  1  frame captured and not yet fully drained
overrun  output  1  sticky: a completion arrived while busy

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, word index=0, holding bank=0, done_prev=0.
- Edge detect: start = done_2_2 & ~done_prev. done_prev registers done_2_2 every cycle. Because done_prev resets to 0, done_2_2 high on the first clock after reset release counts as an edge.
- FSM has two states: IDLE and SEND.
- IDLE, start=1:
  - latch result11/12/21/22 on that clock edge;
  - index=0, go to SEND;
  - out_valid=1, busy=1 from the next cycle (one-cycle capture latency).
- IDLE, start=0: outputs held at idle values (out_valid=0, out_last=0).
- SEND word order: index 0..3 = result11, result12, result21, result22 (raster order). out_data = bank[index], driven combinationally from registered state.
- Handshake:
  - a beat transfers on a clock edge with out_valid & out_ready;
  - while out_valid & ~out_ready, out_data and out_last hold stable;
  - out_valid never drops before transfer.
- out_last=1 only when index=LAST (3, or 4 with the optional feature).
- Transfer at index<LAST: index increments.
- Transfer at LAST with no start that cycle: go to IDLE; out_valid, busy and out_last fall the next cycle.
- Transfer at LAST with start in the same cycle: capture the new results, index=0, stay in SEND. No bubble, no overrun.
- start while in SEND and not at a completing last transfer:
  - the edge is ignored;
  - the bank is not modified;
  - overrun is set to 1 and stays 1 until reset.
- Inputs result* are sampled only on the capture edge. Later changes do not affect the frame in flight.
- Reset mid-frame aborts immediately; no partial frame resumes.
- Throughput: 4 beats per frame with out_ready held high, back-to-back frames possible.

Optional Feature:
Macro CONV_RESULT_MAXPOOL_EN.
- Defined:
  - on capture, a fifth bank word is stored: the unsigned maximum of the four results (ties take any equal value);
  - the frame is 5 words (index 4 = max), out_last on index 4, LAST=4.
- Undefined:
  - no comparator logic is built;
  - the frame is 4 words, LAST=3, out_last on index 3.

Test Plan:
- Basic frame: reset, then pulse done_2_2 with results 12,10,9,10 and out_ready=1. Required: out_valid rises one cycle after the edge; beats 12,10,9,10 on consecutive cycles; out_last only on 10 (the fourth beat); busy falls after it. With MAXPOOL_EN: a fifth beat of 12 with out_last.
- Backpressure: same frame, out_ready low for 3 cycles at index 1. Required: out_data=10 and out_valid=1 held stable throughout; no word skipped or duplicated.
- Level done: done_2_2 held high for 10 cycles. Required: exactly one frame emitted; overrun stays 0.
- Overrun: second done_2_2 rising edge during index 1 with results 1,2,3,4. Required: first frame (12,10,9,10) completes unchanged; overrun=1 and sticky; no second frame.
- Back-to-back: new edge with results 1,2,3,4 on the cycle of the last-beat transfer. Required: next cycle out_valid=1 with out_data=1; overrun=0.
- Async reset: assert rst=0 mid-clock during index 2. Required: out_valid, busy, overrun and out_data go to 0 immediately; after release, the bench expects no output until a new done_2_2 edge.
